// File: rtl/psram_pkg.sv
// Shared definitions for the synchronous-burst PSRAM link (controller and responder).
package psram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LAT   = 2'd1,
        ST_WRITE = 2'd2,
        ST_READ  = 2'd3
    } psram_state_e;

    localparam int PSRAM_ADR_W = 23;
    localparam int PSRAM_DAT_W = 16;

    localparam int PSRAM_LATENCY_MIN = 2;
    localparam int PSRAM_LATENCY_MAX = 7;

endpackage

// File: rtl/psram_resp_mem.sv
// Responder word store: one synchronous write port, asynchronous read at the same pointer.
module psram_resp_mem
    import psram_pkg::*;
#(
    parameter int ADR_W = 8
) (
    input  logic                   clk_i,
    input  logic                   i_we,
    input  logic [ADR_W-1:0]       i_adr,
    input  logic [PSRAM_DAT_W-1:0] i_wdat,
    output logic [PSRAM_DAT_W-1:0] o_rdat
);

    logic [PSRAM_DAT_W-1:0] r_mem [2**ADR_W];

    // Contents survive reset on purpose so a self-test can read back after a reset.
    always_ff @(posedge clk_i) begin
        if (i_we) begin
            r_mem[i_adr] <= i_wdat;
        end
    end

    assign o_rdat = r_mem[i_adr];

endmodule

// File: rtl/psram_burst_responder.sv
// Device end of the burst PSRAM link: address decode, fixed initial latency,
// continuous bursts into/out of a small on-chip word memory.
//
// state   | meaning
// IDLE    | no burst open
// LAT     | initial latency, psram_wait high
// WRITE   | each data edge stores psram_dat_i at ptr
// READ    | each data edge presents the next word one edge ahead
module psram_burst_responder
    import psram_pkg::*;
#(
    parameter int ADR_W   = 8,
    parameter int LATENCY = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [PSRAM_ADR_W-1:0] psram_adr,
    input  logic [PSRAM_DAT_W-1:0] psram_dat_i,
    output logic [PSRAM_DAT_W-1:0] psram_dat_o,
    output logic                   psram_dat_oe,
    output logic                   psram_wait,
    input  logic                   psram_ce_n,
    input  logic                   psram_adv_n,
    input  logic                   psram_we_n,
    input  logic                   psram_oe_n
);

    localparam logic [2:0]       CNT_LOAD = 3'(LATENCY - 2);
    localparam logic [ADR_W-1:0] PTR_ONE  = ADR_W'(1);

    psram_state_e           r_state;
    logic [ADR_W-1:0]       r_ptr;
    logic [2:0]             r_cnt;
    logic                   r_wr;
    logic [PSRAM_DAT_W-1:0] r_dat_o;
    logic                   r_dat_oe;
    logic                   r_wait;

    logic                   w_data_edge;
    logic                   w_mem_we;
    logic [PSRAM_DAT_W-1:0] w_rdat;
    logic                   w_adr_unused;

    // Upper address bits beyond the internal depth are deliberately ignored.
    assign w_adr_unused = ^psram_adr[PSRAM_ADR_W-1:ADR_W];

    assign w_data_edge = ~psram_ce_n & psram_adv_n;
    assign w_mem_we    = ~rst_i & w_data_edge & (r_state == ST_WRITE);

    psram_resp_mem #(
        .ADR_W (ADR_W)
    ) u_mem (
        .clk_i  (clk_i),
        .i_we   (w_mem_we),
        .i_adr  (r_ptr),
        .i_wdat (psram_dat_i),
        .o_rdat (w_rdat)
    );

    // Burst FSM with pointer, latency counter and registered bus outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_ptr    <= '0;
            r_cnt    <= '0;
            r_wr     <= 1'b0;
            r_dat_o  <= '0;
            r_dat_oe <= 1'b0;
            r_wait   <= 1'b0;
        end else if (psram_ce_n) begin
            r_state  <= ST_IDLE;
            r_wait   <= 1'b0;
            r_dat_oe <= 1'b0;
        end else if (!psram_adv_n) begin
            // Address edge: restarts from any state, aborting an open burst.
            r_state  <= ST_LAT;
            r_ptr    <= psram_adr[ADR_W-1:0];
            r_wr     <= ~psram_we_n;
            r_cnt    <= CNT_LOAD;
            r_wait   <= 1'b1;
            r_dat_oe <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                end
                ST_LAT: begin
                    if (r_cnt != 3'd0) begin
                        r_cnt <= r_cnt - 3'd1;
                    end else if (r_wr) begin
                        r_state <= ST_WRITE;
                        r_wait  <= 1'b0;
                    end else begin
                        // Prefetch the first word so it is on the bus at the first data edge.
                        r_state  <= ST_READ;
                        r_wait   <= 1'b0;
                        r_dat_o  <= w_rdat;
                        r_ptr    <= r_ptr + PTR_ONE;
                        r_dat_oe <= ~psram_oe_n;
                    end
                end
                ST_WRITE: begin
                    r_ptr <= r_ptr + PTR_ONE;
                end
                ST_READ: begin
                    r_dat_o  <= w_rdat;
                    r_ptr    <= r_ptr + PTR_ONE;
                    r_dat_oe <= ~psram_oe_n;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign psram_dat_o  = r_dat_o;
    assign psram_dat_oe = r_dat_oe;
    assign psram_wait   = r_wait;

endmodule

// File: tb/tb_psram_burst_responder.sv
// Bench for psram_burst_responder: edge-counting reference model checked every cycle,
// directed scenarios with literal expectations, then randomized bus traffic.
module tb_psram_burst_responder;

    localparam int LAT = 3;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [22:0] psram_adr = '0;
    logic [15:0] psram_dat_i = '0;
    logic [15:0] psram_dat_o;
    logic        psram_dat_oe;
    logic        psram_wait;
    logic        psram_ce_n = 1'b1;
    logic        psram_adv_n = 1'b1;
    logic        psram_we_n = 1'b1;
    logic        psram_oe_n = 1'b1;

    int checks = 0;
    int failures = 0;

    psram_burst_responder #(
        .ADR_W   (8),
        .LATENCY (LAT)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .psram_adr    (psram_adr),
        .psram_dat_i  (psram_dat_i),
        .psram_dat_o  (psram_dat_o),
        .psram_dat_oe (psram_dat_oe),
        .psram_wait   (psram_wait),
        .psram_ce_n   (psram_ce_n),
        .psram_adv_n  (psram_adv_n),
        .psram_we_n   (psram_we_n),
        .psram_oe_n   (psram_oe_n)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: counts edges since the address edge and derives outputs from that.
    logic [15:0] m_mem [256];
    logic        m_act = 1'b0;
    int          m_n = 0;
    logic [7:0]  m_a = '0;
    logic        m_wr = 1'b0;
    logic [15:0] m_dat = '0;
    logic        m_oe = 1'b0;
    logic        m_wait = 1'b0;
    logic        m_valid = 1'b0;

    always @(posedge clk_i) begin
        int k;
        if (rst_i) begin
            m_act = 1'b0; m_dat = '0; m_oe = 1'b0; m_wait = 1'b0; m_valid = 1'b1;
        end else if (psram_ce_n) begin
            m_act = 1'b0; m_wait = 1'b0; m_oe = 1'b0;
        end else if (!psram_adv_n) begin
            m_act = 1'b1; m_n = 0; m_a = psram_adr[7:0]; m_wr = !psram_we_n;
            m_wait = 1'b1; m_oe = 1'b0;
        end else if (m_act) begin
            m_n = m_n + 1;
            if (m_n < LAT - 1) begin
                m_wait = 1'b1;
            end else if (m_n == LAT - 1) begin
                m_wait = 1'b0;
                if (!m_wr) begin
                    m_dat = m_mem[m_a];
                    m_oe  = !psram_oe_n;
                end
            end else begin
                k = m_n - LAT;
                if (m_wr) begin
                    m_mem[m_a + 8'(k)] = psram_dat_i;
                end else begin
                    m_dat = m_mem[m_a + 8'(k + 1)];
                    m_oe  = !psram_oe_n;
                end
            end
        end
        #1;
        if (m_valid) begin
            checks = checks + 3;
            if (psram_dat_o !== m_dat) begin
                failures++;
                $display("FAIL model_dat_o t=%0t actual=%h required=%h", $time, psram_dat_o, m_dat);
            end
            if (psram_dat_oe !== m_oe) begin
                failures++;
                $display("FAIL model_dat_oe t=%0t actual=%b required=%b", $time, psram_dat_oe, m_oe);
            end
            if (psram_wait !== m_wait) begin
                failures++;
                $display("FAIL model_wait t=%0t actual=%b required=%b", $time, psram_wait, m_wait);
            end
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Apply one set of bus inputs and return shortly after the edge that samples them.
    task automatic drive(input logic ce_n, input logic adv_n, input logic we_n, input logic oe_n,
                         input logic [22:0] a, input logic [15:0] d);
        psram_ce_n = ce_n; psram_adv_n = adv_n; psram_we_n = we_n; psram_oe_n = oe_n;
        psram_adr = a; psram_dat_i = d;
        @(posedge clk_i);
        #2;
    endtask

    task automatic idle_edge();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 23'd0, 16'd0);
    endtask

    task automatic wr_burst(input logic [22:0] a, input int n, input logic [15:0] base);
        drive(1'b0, 1'b0, 1'b0, 1'b1, a, 16'd0);
        for (int i = 0; i < LAT - 1; i++) drive(1'b0, 1'b1, 1'b1, 1'b1, a, 16'd0);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b1, 1'b1, a, base + 16'(i));
        idle_edge();
    endtask

    // Address edge plus latency; on return the first word is on psram_dat_o.
    task automatic rd_open(input logic [22:0] a, input logic oe_n);
        drive(1'b0, 1'b0, 1'b1, oe_n, a, 16'd0);
        for (int i = 0; i < LAT - 1; i++) drive(1'b0, 1'b1, 1'b1, oe_n, a, 16'd0);
    endtask

    task automatic rd_step(input logic oe_n);
        drive(1'b0, 1'b1, 1'b1, oe_n, 23'd0, 16'd0);
    endtask

    initial begin
        // Reset wins over a simultaneous address edge.
        rst_i = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 23'h12D687, 16'hFFFF);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 23'h12D687, 16'hFFFF);
        chk("rst_dat_o", psram_dat_o, 16'h0000);
        chk("rst_dat_oe", {15'd0, psram_dat_oe}, 16'd0);
        chk("rst_wait", {15'd0, psram_wait}, 16'd0);
        rst_i = 1'b0;
        idle_edge();

        // Known contents everywhere: word i = 0xC000 | i.
        wr_burst(23'd0, 256, 16'hC000);

        // Write 89..92 at 1234567 (ptr 0x87).
        drive(1'b0, 1'b0, 1'b0, 1'b1, 23'd1234567, 16'd0);
        chk("wr_wait_e0", {15'd0, psram_wait}, 16'd1);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 23'd0, 16'd0);
        chk("wr_wait_e1", {15'd0, psram_wait}, 16'd1);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 23'd0, 16'd0);
        chk("wr_wait_e2", {15'd0, psram_wait}, 16'd0);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b1, 1'b1, 23'd0, 16'(89 + i));
        idle_edge();

        rd_open(23'd1234567, 1'b0);
        chk("rd_oe_e2", {15'd0, psram_dat_oe}, 16'd1);
        chk("rd_dat_0", psram_dat_o, 16'd89);
        for (int i = 1; i < 4; i++) begin
            rd_step(1'b0);
            chk("rd_dat_n", psram_dat_o, 16'(89 + i));
        end
        idle_edge();

        // Pointer wrap.
        wr_burst(23'h0000FE, 4, 16'h00A1);
        rd_open(23'h0000FE, 1'b0);
        chk("wrap_fe", psram_dat_o, 16'h00A1);
        rd_step(1'b0);
        chk("wrap_ff", psram_dat_o, 16'h00A2);
        idle_edge();
        rd_open(23'h000000, 1'b0);
        chk("wrap_00", psram_dat_o, 16'h00A3);
        rd_step(1'b0);
        chk("wrap_01", psram_dat_o, 16'h00A4);
        idle_edge();

        // Abort in latency: data edges after the abort must not write.
        wr_burst(23'h000040, 1, 16'h1111);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 23'h000040, 16'h2222);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 23'h000040, 16'h2222);
        chk("abort_wait", {15'd0, psram_wait}, 16'd0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1, 1'b1, 23'h000040, 16'h2222);
        idle_edge();
        rd_open(23'h000040, 1'b0);
        chk("abort_old", psram_dat_o, 16'h1111);
        idle_edge();

        // Read with oe_n high: data still steps, bus not driven.
        rd_open(23'd1234567, 1'b1);
        chk("oeh_oe", {15'd0, psram_dat_oe}, 16'd0);
        chk("oeh_dat0", psram_dat_o, 16'd89);
        rd_step(1'b1);
        chk("oeh_dat1", psram_dat_o, 16'd90);
        chk("oeh_oe1", {15'd0, psram_dat_oe}, 16'd0);
        idle_edge();

        // Restart at E4 of a read to address 0x10.
        rd_open(23'd1234567, 1'b0);
        rd_step(1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 23'h000010, 16'd0);
        chk("rs_wait_e4", {15'd0, psram_wait}, 16'd1);
        rd_step(1'b0);
        chk("rs_wait_e5", {15'd0, psram_wait}, 16'd1);
        rd_step(1'b0);
        chk("rs_wait_e6", {15'd0, psram_wait}, 16'd0);
        chk("rs_dat_e6", psram_dat_o, 16'hC010);
        idle_edge();

        // Randomized traffic, checked by the model every cycle.
        for (int i = 0; i < 4000; i++) begin
            rst_i = ($urandom_range(0, 299) == 0);
            drive($urandom_range(0, 19) == 0, $urandom_range(0, 11) != 0,
                  1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                  23'($urandom), 16'($urandom));
        end
        rst_i = 1'b0;
        idle_edge();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/psram_burst_responder.md
# psram_burst_responder

Synthesizable responder for the synchronous-burst PSRAM bus, acting as the device end of the link driven by `psram_burst_controller`. It decodes CE#/ADV#/WE#/OE# and latches the address, then applies a fixed initial latency. Burst data is moved into or out of a small on-chip word memory. It is used as the controller's loopback partner in simulation and in on-board self-test builds.

## Interface
Parameters:
- `ADR_W`, 8: internal memory depth is 2^ADR_W words. Upper `psram_adr` bits are ignored.
- `LATENCY`, 3: clock edges from the address edge to the first data edge. Legal range is 2..7.

Ports:
- `clk_i` in 1: single clock. All bus signals are sampled on its rising edge.
- `rst_i` in 1: reset, synchronous and active-high.
- `psram_adr` in 23: address from the controller.
- `psram_dat_i` in 16: write data from the controller.
- `psram_dat_o` out 16: read data to the controller, registered.
- `psram_dat_oe` out 1: responder drives the data bus, registered.
- `psram_wait` out 1: active-high initial-latency indication, registered.
- `psram_ce_n` in 1: chip enable, active-low.
- `psram_adv_n` in 1: address valid, active-low.
- `psram_we_n` in 1: write enable, active-low. It is sampled only on the address edge.
- `psram_oe_n` in 1: output enable, active-low.

## Operation
- States are IDLE, LAT, WRITE and READ.
- **Address edge.** An edge with `ce_n`=0 and `adv_n`=0, taken from any state, does the following:
  - latches `ptr <= psram_adr[ADR_W-1:0]`;
  - latches `wr <= ~we_n`;
  - loads `cnt <= LATENCY-2`;
  - moves to LAT. If LATENCY=2, it moves to the data state on the next edge.
- **LAT.** On each edge with `ce_n`=0 and `adv_n`=1:
  - if `cnt`≠0, decrement `cnt`;
  - if `cnt`=0, go to WRITE (wr=1) or READ (wr=0).
- **Entering READ.** On the transition edge, `psram_dat_o <= mem[ptr]` and `ptr <= ptr+1`.
- **WRITE.** On each edge with `ce_n`=0 and `adv_n`=1: `mem[ptr] <= psram_dat_i`, then `ptr <= ptr+1`.
- **READ.** On each edge with `ce_n`=0 and `adv_n`=1: `psram_dat_o <= mem[ptr]`, then `ptr <= ptr+1`. The word is presented one edge ahead so the controller samples it on the data edge.
- **Burst length.** Bursts are continuous with no fixed length. They end only when `ce_n` is high.
- **Pointer wrap.** `ptr` wraps modulo 2^ADR_W, so 0xFF+1 becomes 0x00 for ADR_W=8.
- **`psram_ce_n`=1 on any edge.** Go to IDLE and clear `psram_wait` and `psram_dat_oe`. There is no memory write on that edge.
- **Restart.** An address edge seen in LAT, WRITE or READ aborts the current burst and restarts with the new address.
- **`psram_dat_oe`** is registered as `1` when the next state is READ and `oe_n`=0. With `oe_n`=1, READ still advances `ptr` and updates `psram_dat_o`, but `psram_dat_oe` stays 0.
- **`psram_wait`** is 1 while in LAT. It is registered to the next state, so it is high from the address edge until the edge that enters WRITE/READ.
- **Reset** (`rst_i`=1 on an edge) sets:
  - state IDLE;
  - `ptr`=0 and `cnt`=0;
  - `psram_dat_o`=0, `psram_dat_oe`=0, `psram_wait`=0.
  
  Memory contents are not cleared. Reset takes priority over all bus activity, including an address edge in the same cycle.

## Timing
- Edges are numbered with the address edge as E0.
- LAT occupies the states after E0 .. E(LATENCY-2). `psram_wait`=1 after each of those edges.
- The edge E(LATENCY-1) enters the data state. After it, `psram_wait`=0.
  - Read: `psram_dat_o`=mem[A] and `psram_dat_oe`=1 after E(LATENCY-1).
- Data edge k (k≥0) is E(LATENCY+k).
  - Write: stores `psram_dat_i` at A+k.
  - Read: the controller samples mem[A+k], then `psram_dat_o` becomes mem[A+k+1].
- With LATENCY=3: wait is high after E0 and E1, the first write or read transfer is at E3, and one word moves per edge after that.
- The memory has one write port and one asynchronous read port. The write on an edge is visible to a read on the following edge. Read and write never occur on the same edge.

## Structure
- Package `psram_pkg` holds:
  - the state enum (IDLE, LAT, WRITE, READ);
  - `PSRAM_ADR_W`=23 and `PSRAM_DAT_W`=16;
  - `LATENCY` bound constants (min 2, max 7), shared with the controller.
- Sub-module `psram_resp_mem`: 2^ADR_W x 16 words, synchronous write, asynchronous read (distributed RAM).
- The top level holds the FSM, `ptr`, `cnt` and the output registers.

## Test plan
All scenarios use ADR_W=8 and LATENCY=3.
- **Reset.** Hold `rst_i` for 2 edges with `ce_n`=0 and `adv_n`=0 → `psram_dat_o`=0, `psram_dat_oe`=0, `psram_wait`=0, state IDLE.
- **Write then read back.**
  - Address 1234567 (ptr 0x87), we_n=0, with 89,90,91,92 presented at E3..E6, then `ce_n`=1 → `psram_wait` high after E0 and E1.
  - Read the same address with `oe_n`=0 → `psram_dat_o` is 89,90,91,92 while sampled at E3..E6, and `psram_dat_oe`=1 from after E2.
- **Wrap.** Write 0xA1..0xA4 starting at address 0xFE → read bursts from 0xFE and from 0x00 return A1,A2 and A3,A4 respectively.
- **Abort in latency.** `ce_n`=1 at E1 of a write → after E1 state IDLE and `psram_wait`=0. A later read of that address returns the old contents.
- **oe_n high.** A read burst with `oe_n`=1 → `psram_dat_oe` stays 0 and `psram_dat_o` still steps mem[A], mem[A+1], ...
- **Restart.** An address edge to 0x10 at E4 of a read at 0x87 → `psram_wait` high again after E4 and E5, and data from mem[0x10] is sampled at E7.
